// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - func codes, FSM states and op kinds for the HI/LO multiply/divide sequencer
package muldiv_pkg;

    // R-type func field values of the HI/LO instruction class
    localparam logic [5:0] FUNC_MFHI  = 6'b010000;
    localparam logic [5:0] FUNC_MTHI  = 6'b010001;
    localparam logic [5:0] FUNC_MFLO  = 6'b010010;
    localparam logic [5:0] FUNC_MTLO  = 6'b010011;
    localparam logic [5:0] FUNC_MULT  = 6'b011000;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIXUP = 2'd2
    } state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

endpackage

// File: rtl/muldiv_iter_step.sv
// rtl/muldiv_iter_step.sv - one shift-add multiply or restoring shift-subtract divide step
module muldiv_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opb_i,
    output logic [2*WIDTH-1:0] acc_o
);

    // acc holds {partial, operand}: multiply adds into the upper half then shifts right,
    // divide shifts left, trial-subtracts the divisor and shifts in the quotient bit
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Single combinational iteration; a borrow in diff means the trial subtract failed
    always_comb begin
        sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opb_i} : {(WIDTH+1){1'b0}});
        shifted = acc_i[2*WIDTH-1:WIDTH-1];
        diff    = shifted - {1'b0, opb_i};
        if (is_div_i) begin
            if (diff[WIDTH]) begin
                acc_o = {shifted[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end else begin
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq_ctr.sv
// rtl/muldiv_seq_ctr.sv - HI/LO owner and iterative MULT/DIV sequencer for the EX stage
module muldiv_seq_ctr
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [0:5]       func,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done,
    output logic             dz
);

    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic               dzf_q, dzf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               accept;
    logic               is_mul_func;
    logic               is_div_func;
    logic               is_signed_func;
    logic               neg_a;
    logic               neg_b;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod;

    assign busy   = (state_q != ST_IDLE);
    assign stall  = valid & busy;
    assign accept = valid & ~busy & ~flush;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign done   = done_q;
    assign dz     = dz_q;

    assign is_mul_func    = (func == FUNC_MULT) || (func == FUNC_MULTU);
    assign is_div_func    = (func == FUNC_DIV)  || (func == FUNC_DIVU);
    assign is_signed_func = (func == FUNC_MULT) || (func == FUNC_DIV);
    assign neg_a          = is_signed_func & rs_val[WIDTH-1];
    assign neg_b          = is_signed_func & rt_val[WIDTH-1];

    muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (op_q == OP_DIV),
        .acc_i    (acc_q),
        .opb_i    (opb_q),
        .acc_o    (step_acc)
    );

    // State register plus all datapath registers; reset clears HI/LO too
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MUL;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dzf_q   <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dzf_q   <= dzf_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    // Next state: accept/latch in IDLE, iterate in RUN, sign-correct and commit in FIXUP
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dzf_d   = dzf_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        prod    = acc_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (func == FUNC_MTHI) begin
                        hi_d = rs_val;
                    end else if (func == FUNC_MTLO) begin
                        lo_d = rs_val;
                    end else if (is_mul_func || is_div_func) begin
                        // Magnitudes go into the iterator; signs are reapplied in FIXUP
                        op_d    = is_div_func ? OP_DIV : OP_MUL;
                        sa_d    = neg_a;
                        sb_d    = neg_b;
                        dzf_d   = is_div_func && (rt_val == '0);
                        acc_d   = {{WIDTH{1'b0}}, (neg_a ? (-rs_val) : rs_val)};
                        opb_d   = neg_b ? (-rt_val) : rt_val;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                acc_d = step_acc;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = ST_FIXUP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FIXUP: begin
                if (op_q == OP_MUL) begin
                    prod = (sa_q ^ sb_q) ? (-acc_q) : acc_q;
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else begin
                    // Divide by zero leaves remainder = |rs|, so the dividend-sign rule restores raw rs
                    hi_d = sa_q ? (-acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
                    if (dzf_q) begin
                        lo_d = '1;
                    end else begin
                        lo_d = (sa_q ^ sb_q) ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
                    end
                end
                done_d  = 1'b1;
                dz_d    = dzf_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A flush abandons the op before anything reaches HI/LO
        if (flush && busy) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
            dz_d    = 1'b0;
        end
    end

endmodule

// File: tb/tb_muldiv_seq_ctr.sv
// tb/tb_muldiv_seq_ctr.sv - self-checking bench for muldiv_seq_ctr
module tb_muldiv_seq_ctr;

    localparam int W = 32;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid;
    logic [0:5]   func;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic         flush;
    logic         busy;
    logic         stall;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         done;
    logic         dz;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_seq_ctr #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .valid  (valid),
        .func   (func),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo),
        .done   (done),
        .dz     (dz)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural result {hi,lo} from plain arithmetic on the operand values
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] q;
        logic signed [63:0] r;
        sa = $signed(a);
        sb = $signed(b);
        if (f == F_MULT) begin
            return sa * sb;
        end else if (f == F_MULTU) begin
            return {32'b0, a} * {32'b0, b};
        end else if (b == 32'd0) begin
            return {a, 32'hFFFF_FFFF};
        end else if (f == F_DIV) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end else begin
            return {a % b, a / b};
        end
    endfunction

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        logic        dz_exp;
        int          n;
        bit          seen;
        exp    = model(f, a, b);
        dz_exp = ((f == F_DIV) || (f == F_DIVU)) && (b == 32'd0);
        valid  = 1'b1;
        func   = f;
        rs_val = a;
        rt_val = b;
        step();
        valid = 1'b0;
        func  = 6'b000000;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            step();
            n++;
            if (done) seen = 1'b1;
        end
        chk({tag, "_latency"}, 64'(n), 64'(W + 1));
        chk({tag, "_hi"}, 64'(hi), 64'(exp[63:32]));
        chk({tag, "_lo"}, 64'(lo), 64'(exp[31:0]));
        chk({tag, "_dz"}, 64'(dz), 64'(dz_exp));
        chk({tag, "_busy_low"}, 64'(busy), 64'd0);
        step();
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp;
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        bit          stall_ok;
        bit          seen;

        reset  = 1'b1;
        valid  = 1'b0;
        func   = 6'b000000;
        rs_val = '0;
        rt_val = '0;
        flush  = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_dz", 64'(dz), 64'd0);

        run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg", F_MULT, 32'hFFFF_FFFD, 32'd7);
        chk("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_zero", F_DIVU, 32'd100, 32'd0);
        chk("divu_zero_const", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
        run_op("div_zero_neg", F_DIV, 32'hFFFF_FFF9, 32'd0);
        run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);

        // MFLO five cycles after a MULT must stall until busy falls
        a = 32'hFFFF_F000;
        b = 32'd12345;
        exp    = model(F_MULT, a, b);
        valid  = 1'b1;
        func   = F_MULT;
        rs_val = a;
        rt_val = b;
        step();
        valid = 1'b0;
        repeat (4) step();
        valid = 1'b1;
        func  = F_MFLO;
        #1;
        n        = 0;
        stall_ok = 1'b1;
        while (busy && n < 100) begin
            if (!stall) stall_ok = 1'b0;
            step();
            n++;
        end
        chk("mflo_stall_held", 64'(stall_ok), 64'd1);
        chk("mflo_stall_len", 64'(n), 64'(W - 3));
        chk("mflo_stall_release", 64'(stall), 64'd0);
        chk("mflo_lo", 64'(lo), 64'(exp[31:0]));
        valid = 1'b0;
        func  = 6'b000000;
        step();

        // MTHI/MTLO and an ignored func
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mthi_pre", 64'(hi), 64'd0);
        valid  = 1'b1;
        func   = F_MTHI;
        rs_val = 32'h0000_1234;
        step();
        chk("mthi_hi", 64'(hi), 64'h1234);
        func   = F_MTLO;
        rs_val = 32'h0000_5678;
        step();
        chk("mtlo_lo", 64'(lo), 64'h5678);
        func   = F_ADD;
        rs_val = 32'hDEAD_BEEF;
        step();
        chk("ignored_busy", 64'(busy), 64'd0);
        chk("ignored_hilo", {hi, lo}, 64'h0000_1234_0000_5678);
        func = F_MFHI;
        step();
        chk("mfhi_noop", {hi, lo}, 64'h0000_1234_0000_5678);

        // Flush during RUN abandons the divide
        func   = F_DIV;
        rs_val = 32'd1000;
        rt_val = 32'd7;
        step();
        valid = 1'b0;
        repeat (10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_hilo", {hi, lo}, 64'h0000_1234_0000_5678);
        seen = 1'b0;
        repeat (40) begin
            step();
            if (done || dz) seen = 1'b1;
        end
        chk("flush_no_done", 64'(seen), 64'd0);
        chk("flush_hilo_late", {hi, lo}, 64'h0000_1234_0000_5678);

        // Flush and valid together: nothing accepted
        valid  = 1'b1;
        flush  = 1'b1;
        func   = F_MTLO;
        rs_val = 32'hDEAD_0000;
        step();
        chk("flush_valid_mtlo", 64'(lo), 64'h5678);
        func = F_MULT;
        step();
        chk("flush_valid_mult", 64'(busy), 64'd0);
        valid = 1'b0;
        flush = 1'b0;
        step();

        // Reset in the middle of RUN
        valid  = 1'b1;
        func   = F_DIV;
        rs_val = 32'd999;
        rt_val = 32'd3;
        step();
        valid = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        chk("rst_mid_done", 64'(done), 64'd0);

        // Randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       f = F_MULT;
                1:       f = F_MULTU;
                2:       f = F_DIV;
                default: f = F_DIVU;
            endcase
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
            run_op("rand", f, a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
